rx_enable_scheduler: RTL and testbench
======================================

RX_ENABLE_SCHEDULER -- requirements
Module: rx_enable_scheduler

Interface
REQ-001 Parameter N, default 4: number of QDI2Bin_RxEnable_1of2 receivers served, 2..8.
REQ-002 Parameter TIMEOUT, default 255: maximum grant cycles before abort, 1..65535.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 valid  input  N  per-receiver valid, asynchronous to CLK.
REQ-006 dout  input  N  per-receiver data bit, asynchronous to CLK.
REQ-007 rxe  output  N  per-receiver rx enable; at most one bit high.
REQ-008 out_data  output  1  captured data bit.
REQ-009 out_ch  output  clog2(N)  channel index of out_data.
REQ-010 out_valid  output  1  output token present.
REQ-011 out_ready  input  1  consumer accepts token when high with out_valid.
REQ-012 timeout_err  output  N  sticky per-channel abort flags.
REQ-013 err_clr  input  1  clears all timeout_err bits when high for one cycle.

Function
REQ-014 Each valid bit SHALL pass through a 2-flop synchronizer; vs[i] denotes the synchronized value.
- FSM states: IDLE, GRANT, RELEASE, OUTPUT.
REQ-015 IDLE: if any vs high, pick the first requester at or after the round-robin pointer, wrapping N-1 to 0, assert that rxe bit next cycle, and go to GRANT.
REQ-016 Pointer SHALL advance to granted index +1, mod N, on each grant; no grant when no vs is high.
REQ-017 GRANT: hold rxe; the grant cycle counter increments from 0; when vs[g] reads low (receiver consumed the token and dropped valid), capture dout[g] into out_data, drop rxe, and go to OUTPUT.
REQ-018 dout[g] SHALL be sampled directly, not synchronized, since it has been stable since rxe assertion and is held after valid falls.
REQ-019 GRANT timeout: when the counter reaches TIMEOUT with vs[g] still high, drop rxe, set timeout_err[g], produce no output token, and go to RELEASE.
REQ-020 RELEASE: wait one cycle, then go to IDLE; the aborted channel is re-arbitrated normally.
REQ-021 OUTPUT: out_valid high with out_data/out_ch stable until the cycle out_ready is high; then drop out_valid and go to IDLE next cycle.
REQ-022 No new grant SHALL issue while out_valid is high (single-entry buffer; backpressure holds all receivers).
REQ-023 err_clr coincident with a new timeout SHALL leave that new bit set.
REQ-024 Minimum token latency, vs falling to out_valid high: 1 cycle.

Reset
REQ-025 RESET low SHALL immediately force: state IDLE, rxe 0, out_valid 0, out_data 0, out_ch 0, timeout_err 0, pointer 0, counters 0, synchronizers 0.
REQ-026 Reset mid-GRANT SHALL drop rxe asynchronously; no partial token SHALL be output after release.
REQ-027 The first grant after RESET rises SHALL occur no earlier than 3 cycles after release.

Configuration
REQ-028 Macro RX_ENABLE_SCHEDULER_TOKEN_CNT_EN: when defined, adds output tok_cnt (N x 16 bits, flat); each 16-bit slice counts completed tokens for its channel, wraps 65535 to 0, is cleared by reset, and excludes aborted tokens.
REQ-029 When the macro is undefined, tok_cnt and its counters SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Single token: valid[2] rises, receiver drops it 5 cycles after rxe[2] with dout[2]=1 -> rxe=0100 until valid falls; out_valid with out_data=1, out_ch=2.
REQ-031 Fairness: valid=1111 held, out_ready=1 -> grant order 0,1,2,3,0; never two rxe bits high.
REQ-032 Backpressure: out_ready=0 for 10 cycles with valid[1] pending -> out_valid held, data stable, rxe stays 0; grant follows out_ready.
REQ-033 Timeout: TIMEOUT=8, valid[3] never falls -> rxe[3] drops after 8 grant cycles, timeout_err=1000, no out_valid; err_clr -> 0000.
REQ-034 Reset mid-GRANT: RESET low during rxe[0] high -> rxe=0 without waiting for CLK; after release, no out_valid before a new grant.
REQ-035 With RX_ENABLE_SCHEDULER_TOKEN_CNT_EN defined: 3 completed tokens on channel 1 -> tok_cnt slice 1 = 3, all other slices 0.

Source files
------------

// File: rtl/rx_enable_scheduler.sv
// Round-robin rx-enable scheduler for N QDI 1of2 receivers, with a per-grant timeout and a single-entry output buffer.
// Optional define RX_ENABLE_SCHEDULER_TOKEN_CNT_EN adds tok_cnt, a flat N x 16-bit completed-token counter bus.
module rx_enable_scheduler #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         valid,
  input  logic [N-1:0]         dout,
  output logic [N-1:0]         rxe,
  output logic                 out_data,
  output logic [$clog2(N)-1:0] out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         timeout_err,
  input  logic                 err_clr
`ifdef RX_ENABLE_SCHEDULER_TOKEN_CNT_EN
  ,
  output logic [16*N-1:0]      tok_cnt
`endif
);

  localparam int GW = $clog2(N);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, OUTPUT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    meta_q, vs_q;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   g_q, g_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [N-1:0]    rxe_q, rxe_d;
  logic [N-1:0]    terr_q, terr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_data_q, out_data_d;
  logic [GW-1:0]   out_ch_q, out_ch_d;
  logic            pick_found_s;
  logic [GW-1:0]   pick_idx_s;

  // Round-robin pick: first synchronized requester at or after the pointer.
  always_comb begin
    int idx;
    logic hit;
    idx          = 0;
    hit          = 1'b0;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx          = (int'(ptr_q) + k) % N;
      hit          = vs_q[idx] && !pick_found_s;
      pick_idx_s   = hit ? GW'(idx) : pick_idx_s;
      pick_found_s = pick_found_s | hit;
    end
  end

  // Scheduler next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    rxe_d       = rxe_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    terr_d      = err_clr ? '0 : terr_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = GRANT;
          g_d     = pick_idx_s;
          rxe_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
          cnt_d   = 16'd0;
          ptr_d   = (pick_idx_s == GW'(N - 1)) ? '0 : pick_idx_s + GW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // dout is taken raw: the receiver has held it stable since rxe rose.
        if (!vs_q[g_q]) begin
          out_data_d  = dout[g_q];
          out_ch_d    = g_q;
          out_valid_d = 1'b1;
          rxe_d       = '0;
          state_d     = OUTPUT;
        end else if (cnt_q == TO_LAST) begin
          rxe_d       = '0;
          terr_d[g_q] = 1'b1;
          state_d     = RELEASE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        rxe_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, synchronizer and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      meta_q      <= '0;
      vs_q        <= '0;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= 16'd0;
      rxe_q       <= '0;
      terr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      meta_q      <= valid;
      vs_q        <= meta_q;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      rxe_q       <= rxe_d;
      terr_q      <= terr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign rxe         = rxe_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign timeout_err = terr_q;

`ifdef RX_ENABLE_SCHEDULER_TOKEN_CNT_EN
  logic [16*N-1:0] tok_cnt_q;
  logic            tok_done_s;

  assign tok_done_s = out_valid_q & out_ready;

  // A token completes on the output handshake; aborted grants never get here.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tok_cnt_q <= '0;
    end else if (tok_done_s) begin
      tok_cnt_q[16*int'(out_ch_q) +: 16] <= tok_cnt_q[16*int'(out_ch_q) +: 16] + 16'd1;
    end else begin
      tok_cnt_q <= tok_cnt_q;
    end
  end

  assign tok_cnt = tok_cnt_q;
`endif

endmodule

// File: tb/tb_rx_enable_scheduler.sv
// Bench for rx_enable_scheduler: directed scenarios plus randomized receivers, checked every cycle
// against a transaction-level model of grants, tokens and timeout flags.
module tb_rx_enable_scheduler;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [N-1:0] valid, dout, rxe, timeout_err;
  logic [1:0]   out_ch;
  logic         out_data, out_valid, out_ready, err_clr;
`ifdef RX_ENABLE_SCHEDULER_TOKEN_CNT_EN
  logic [16*N-1:0] tok_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  rx_enable_scheduler #(.N(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .valid(valid), .dout(dout), .rxe(rxe),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef RX_ENABLE_SCHEDULER_TOKEN_CNT_EN
    , .tok_cnt(tok_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_g is the granted channel (-1 none), m_age counts grant cycles, m_tv marks a held token.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_terr = '0;
  int m_g = -1, m_age = 0, m_ptr = 0, m_tc = 0;
  bit m_rel = 0, m_tv = 0, m_td = 0;
  int m_tok [N];

  task automatic model_step();
    logic [N-1:0] vs, nt;
    vs = m_s2;
    nt = err_clr ? '0 : m_terr;
    if (m_g >= 0) begin
      if (!vs[m_g]) begin
        m_tv = 1; m_td = dout[m_g]; m_tc = m_g; m_g = -1;
      end else if (m_age + 1 == TO) begin
        nt[m_g] = 1'b1; m_g = -1; m_rel = 1;
      end else begin
        m_age++;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_tv) begin
      if (out_ready) begin
        m_tv = 0; m_tok[m_tc]++;
      end
    end else if (vs != '0) begin
      for (int k = 0; k < N; k++) begin
        if (vs[(m_ptr + k) % N]) begin
          m_g = (m_ptr + k) % N;
          break;
        end
      end
      m_age = 0;
      m_ptr = (m_g + 1) % N;
    end
    m_terr = nt;
    m_s2 = m_s1;
    m_s1 = valid;
  endtask

  initial begin : model_proc
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) begin
        m_s1 = '0; m_s2 = '0; m_terr = '0; m_g = -1; m_age = 0; m_ptr = 0;
        m_tc = 0; m_rel = 0; m_tv = 0; m_td = 0;
        for (int i = 0; i < N; i++) m_tok[i] = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1) begin
        chk("rxe", rxe, (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
        chk("out_valid", out_valid, m_tv);
        chk("timeout_err", timeout_err, m_terr);
        if (m_tv) begin
          chk("out_data", out_data, m_td);
          chk("out_ch", out_ch, m_tc);
        end
      end
    end
  end

  // Receivers: 0 idle, 1 requesting, 2 dropped valid and waiting for rxe to fall.
  int rst [N];
  int held [N];
  int tgt [N];
  int cool [N];
  bit rand_en = 0;

  task automatic raise(input int i, input int d, input int h);
    valid[i] = 1'b1; dout[i] = d[0]; tgt[i] = h; held[i] = 0; rst[i] = 1;
  endtask

  task automatic rx_step();
    for (int i = 0; i < N; i++) begin
      case (rst[i])
        0: begin
          if (cool[i] > 0) cool[i]--;
          else if (rand_en && $urandom_range(0, 2) == 0)
            raise(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end
        1: begin
          if (m_g == i) begin
            held[i]++;
            if (tgt[i] != 0 && held[i] >= tgt[i]) begin
              valid[i] = 1'b0; rst[i] = 2;
            end
          end else if (held[i] > 0) begin
            held[i] = 0;
            if (rand_en) tgt[i] = int'($urandom_range(0, 6));
          end
        end
        default: begin
          if (m_g != i) begin
            rst[i] = 0;
            cool[i] = rand_en ? int'($urandom_range(0, 3)) : 0;
          end
        end
      endcase
    end
    if (rand_en) begin
      out_ready = ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 19) == 0);
    end else begin
      err_clr = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    rx_step();
  endtask

  initial begin : main_proc
    int n, cnt, got, idx;
    bit reraised;
    logic [N-1:0] prev;
    int ord [5];
    int exp_ord [5] = '{0, 1, 2, 3, 0};

    RESET = 1'b0; valid = '0; dout = '0; out_ready = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < N; i++) begin rst[i] = 0; held[i] = 0; tgt[i] = 1; cool[i] = 0; end
    repeat (3) cyc();
    #2 RESET = 1'b1;
    cyc();
    chk("reset_rxe", rxe, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_ch", out_ch, 0);
    chk("reset_terr", timeout_err, 0);

    // Single token on channel 2 held in the buffer, then backpressure on channel 1.
    out_ready = 1'b0;
    raise(2, 1, 5);
    cyc(); chk("grant_lat_c1", rxe, 0);
    cyc(); chk("grant_lat_c2", rxe, 0);
    cyc(); chk("grant_ch2", rxe, 4'b0100);
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin cyc(); n++; end
    chk("tok1_valid", out_valid, 1);
    chk("tok1_data", out_data, 1);
    chk("tok1_ch", out_ch, 2);
    raise(1, 0, 2);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 1);
      chk("bp_ch", out_ch, 2);
      chk("bp_rxe", rxe, 0);
    end
    out_ready = 1'b1;
    n = 0;
    while (rxe === '0 && n < 20) begin cyc(); n++; end
    chk("bp_grant_follows", rxe, 4'b0010);
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin cyc(); n++; end
    chk("tok2_ch", out_ch, 1);
    chk("tok2_data", out_data, 0);
    repeat (5) cyc();

    // Timeout on channel 3, then clear.
    raise(3, 1, 0);
    n = 0; cnt = 0;
    while (n < 60) begin
      cyc(); n++;
      chk("to_no_token", out_valid, 0);
      if (rxe[3]) cnt++;
      else if (cnt > 0) break;
    end
    chk("to_rxe_cycles", cnt, TO);
    chk("to_err", timeout_err, 4'b1000);
    tgt[3] = 1;
    err_clr = 1'b1;
    cyc();
    chk("err_clr", timeout_err, 0);
    repeat (20) cyc();

    // Reset while channel 0 is granted.
    raise(0, 1, 0);
    n = 0;
    while (rxe[0] !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("rg_granted", rxe, 4'b0001);
    #2 RESET = 1'b0;
    #1 chk("rg_async_drop", rxe, 0);
    valid = '0;
    for (int i = 0; i < N; i++) begin rst[i] = 0; held[i] = 0; end
    cyc();
    #2 RESET = 1'b1;

    // Fairness from a fresh pointer.
    for (int i = 0; i < N; i++) raise(i, i % 2, 1);
    got = 0; reraised = 0; prev = '0; n = 0;
    while (got < 5 && n < 200) begin
      cyc(); n++;
      chk("onehot", ($countones(rxe) <= 1), 1);
      if (got == 0) chk("rg_no_partial", out_valid, 0);
      if (rxe != '0 && prev == '0) begin
        idx = -1;
        for (int j = 0; j < N; j++) if (rxe[j]) idx = j;
        ord[got] = idx;
        got++;
      end
      if (!reraised && got >= 2 && rst[0] == 0) begin raise(0, 0, 1); reraised = 1; end
      prev = rxe;
    end
    chk("fair_count", got, 5);
    for (int k = 0; k < 5; k++) chk("fair_order", ord[k], exp_ord[k]);
    repeat (10) cyc();

    // Randomized receivers, ready and error-clear.
    rand_en = 1;
    repeat (3000) cyc();
    rand_en = 0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) tgt[i] = 1;
    repeat (100) cyc();

`ifdef RX_ENABLE_SCHEDULER_TOKEN_CNT_EN
    for (int i = 0; i < N; i++) chk("tok_cnt", tok_cnt[16*i +: 16], m_tok[i] % 65536);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
